// File: rtl/ctrl_pool_pkg.sv
// Shared types and defaults for the max-pool control stage: ctrl_bus beat
// layout, FSM state encoding and pooling limits.
package ctrl_pool_pkg;

    localparam int LWIDTH   = 10;
    localparam int D_POOL   = 2;
    localparam int POOL_MAX = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // One ctrl_bus beat; bit order is {start, valid, stop}.
    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg;

endpackage

// File: rtl/ctrl_pool_delay.sv
// ctrl_delay: DEPTH-stage shift register of ctrl_reg beats with a synchronous
// active-high clear; q is the beat presented DEPTH cycles earlier.
module ctrl_delay
    import ctrl_pool_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    clr,
    input  ctrl_reg d,
    output ctrl_reg q
);

    ctrl_reg pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/ctrl_pool.sv
// Max-pool control: tracks raster position of the incoming ctrl_bus stream,
// emits window first/last strobes and a decimated ctrl_bus delayed by D_POOL.
// Optional sticky protocol-error output when CTRL_POOL_ERR_EN is defined.
module ctrl_pool
    import ctrl_pool_pkg::*;
#(
    parameter int LWIDTH = ctrl_pool_pkg::LWIDTH,
    parameter int D_POOL = ctrl_pool_pkg::D_POOL
) (
    input  logic              clk,
    input  logic              xrst,
    input  ctrl_reg           in_ctrl,
    input  logic [LWIDTH-1:0] fea_size,
    input  logic [LWIDTH-1:0] pool_size,
    output ctrl_reg           out_ctrl,
    output logic              buf_feat_en,
    output logic              pool_first,
    output logic              pool_last,
`ifdef CTRL_POOL_ERR_EN
    output logic              proto_err,
`endif
    output logic              busy
);

    // Handshake: a pixel is accepted on any cycle with in_ctrl.valid high while
    // running and no start; there is no back-pressure, gaps simply hold counters.

    state_t            state;
    state_t            state_nxt;
    logic [LWIDTH-1:0] fea_r;
    logic [LWIDTH-1:0] lim_r;
    logic [3:0]        pool_r;
    logic [LWIDTH-1:0] x;
    logic [LWIDTH-1:0] y;
    logic [2:0]        wx;
    logic [2:0]        wy;
    logic              done;
    logic [3:0]        age;
    logic [3:0]        stop_cnt;

    logic              acc;
    logic              x_wrap;
    logic              wx_wrap;
    logic              wy_wrap;
    logic              last_c;
    logic              final_c;
    logic              stop_c;
    logic              trunc;
    logic              pending;
    logic              stop_load;
    logic [3:0]        pool_in;
    ctrl_reg           pre;
    ctrl_reg           dly;

    function automatic logic [LWIDTH-1:0] win_lim(input logic [LWIDTH-1:0] f,
                                                  input logic [3:0] p);
        logic [LWIDTH-1:0] q;
        case (p)
            4'd2:    q = f / LWIDTH'(2);
            4'd3:    q = f / LWIDTH'(3);
            4'd4:    q = f / LWIDTH'(4);
            4'd5:    q = f / LWIDTH'(5);
            4'd6:    q = f / LWIDTH'(6);
            4'd7:    q = f / LWIDTH'(7);
            4'd8:    q = f / LWIDTH'(8);
            default: q = f;
        endcase
        return q * LWIDTH'(p);
    endfunction

    assign pool_in = (pool_size != '0 && pool_size <= LWIDTH'(POOL_MAX)) ?
                     pool_size[3:0] : 4'd1;

    assign acc     = in_ctrl.valid && !in_ctrl.start && (state == S_RUN);
    assign x_wrap  = (x == fea_r - LWIDTH'(1));
    assign wx_wrap = ({1'b0, wx} == pool_r - 4'd1);
    assign wy_wrap = ({1'b0, wy} == pool_r - 4'd1);
    assign last_c  = acc && wx_wrap && wy_wrap && (x < lim_r) && (y < lim_r);
    assign final_c = acc && (lim_r != '0) &&
                     (x == lim_r - LWIDTH'(1)) && (y == lim_r - LWIDTH'(1));
    assign stop_c  = acc && in_ctrl.stop;

    // A stop before the final pooled pixel rides on the youngest valid still
    // inside the delay line; age counts cycles since that valid entered it.
    assign trunc     = stop_c && !done && !final_c;
    assign pending   = (age < 4'(D_POOL));
    assign stop_load = trunc && !last_c && pending;

    always_comb begin
        pre       = '0;
        pre.start = in_ctrl.start;
        pre.valid = last_c;
        pre.stop  = final_c || (trunc && (last_c || !pending));
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_ctrl.start) state_nxt = S_RUN;
            S_RUN:   if (!in_ctrl.start && in_ctrl.valid && in_ctrl.stop) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            fea_r       <= '0;
            lim_r       <= '0;
            pool_r      <= '0;
            x           <= '0;
            y           <= '0;
            wx          <= '0;
            wy          <= '0;
            done        <= 1'b0;
            age         <= '0;
            stop_cnt    <= '0;
            buf_feat_en <= 1'b0;
            pool_first  <= 1'b0;
            pool_last   <= 1'b0;
        end else begin
            buf_feat_en <= acc;
            pool_first  <= acc && (wx == 3'd0) && (wy == 3'd0);
            pool_last   <= last_c;

            if (stop_load) begin
                stop_cnt <= 4'(D_POOL) - age;
            end else if (stop_cnt != 4'd0) begin
                stop_cnt <= stop_cnt - 4'd1;
            end

            if (in_ctrl.start) begin
                age <= 4'(D_POOL);
            end else if (last_c) begin
                age <= 4'd1;
            end else if (pending) begin
                age <= age + 4'd1;
            end

            if (in_ctrl.start) begin
                fea_r  <= fea_size;
                pool_r <= pool_in;
                lim_r  <= win_lim(fea_size, pool_in);
                x      <= '0;
                y      <= '0;
                wx     <= '0;
                wy     <= '0;
                done   <= 1'b0;
            end else if (acc) begin
                if (final_c) done <= 1'b1;
                if (x_wrap) begin
                    x  <= '0;
                    wx <= '0;
                    y  <= y + LWIDTH'(1);
                    wy <= wy_wrap ? 3'd0 : wy + 3'd1;
                end else begin
                    x  <= x + LWIDTH'(1);
                    wx <= wx_wrap ? 3'd0 : wx + 3'd1;
                end
            end
        end
    end

    ctrl_delay #(
        .DEPTH (D_POOL)
    ) u_delay (
        .clk (clk),
        .clr (xrst),
        .d   (pre),
        .q   (dly)
    );

    always_comb begin
        out_ctrl      = dly;
        out_ctrl.stop = dly.stop || (stop_cnt == 4'd1);
    end

    assign busy = (state == S_RUN);

`ifdef CTRL_POOL_ERR_EN
    logic [2*LWIDTH-1:0] pix_cnt;
    logic [2*LWIDTH-1:0] pix_nxt;
    logic [2*LWIDTH-1:0] pix_exp;

    assign pix_nxt = pix_cnt + (2*LWIDTH)'(1);
    assign pix_exp = {{LWIDTH{1'b0}}, fea_r} * {{LWIDTH{1'b0}}, fea_r};

    always_ff @(posedge clk) begin
        if (xrst) begin
            pix_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (in_ctrl.start) begin
                pix_cnt <= '0;
            end else if (acc) begin
                pix_cnt <= pix_nxt;
            end
            if ((in_ctrl.valid && state == S_IDLE) ||
                (in_ctrl.start && state == S_RUN) ||
                (stop_c && pix_nxt != pix_exp)) begin
                proto_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pool.sv
// Self-checking bench for ctrl_pool: a raster model predicts window strobes and
// the decimated ctrl_bus, both cycle-stamped in expected queues.
module tb_ctrl_pool;
    import ctrl_pool_pkg::*;

    localparam int LW = 10;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          xrst;
    ctrl_reg       in_ctrl;
    logic [LW-1:0] fea_size;
    logic [LW-1:0] pool_size;
    ctrl_reg       out_ctrl;
    logic          buf_feat_en;
    logic          pool_first;
    logic          pool_last;
    logic          busy;
`ifdef CTRL_POOL_ERR_EN
    logic          proto_err;
`endif

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [34:0] exp_q[$];
    logic [34:0] pool_q[$];

    ctrl_pool #(
        .LWIDTH (LW),
        .D_POOL (D)
    ) dut (
        .clk         (clk),
        .xrst        (xrst),
        .in_ctrl     (in_ctrl),
        .fea_size    (fea_size),
        .pool_size   (pool_size),
        .out_ctrl    (out_ctrl),
        .buf_feat_en (buf_feat_en),
        .pool_first  (pool_first),
        .pool_last   (pool_last),
`ifdef CTRL_POOL_ERR_EN
        .proto_err   (proto_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entries are {cycle, start, valid, stop} and {cycle, buf_feat_en, first, last}.
    always @(negedge clk) begin
        if (out_ctrl != '0) begin
            if (exp_q.size() == 0) check_eq("out_extra", {cyc, out_ctrl}, 64'd0);
            else check_eq("out_ctrl", {cyc, out_ctrl}, exp_q.pop_front());
        end
        if (buf_feat_en || pool_first || pool_last) begin
            if (pool_q.size() == 0) check_eq("pool_extra", {cyc, buf_feat_en, pool_first, pool_last}, 64'd0);
            else check_eq("pool_strobe", {cyc, buf_feat_en, pool_first, pool_last}, pool_q.pop_front());
        end
    end

    task automatic do_reset(input int n);
        xrst    = 1'b1;
        in_ctrl = '0;
        repeat (n) tick();
        xrst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_ctrl", out_ctrl, 64'd0);
        check_eq("rst_strobes", {buf_feat_en, pool_first, pool_last}, 64'd0);
        check_eq("rst_busy", busy, 64'd0);
        check_eq("rst_exp_q_empty", exp_q.size(), 64'd0);
        check_eq("rst_pool_q_empty", pool_q.size(), 64'd0);
    endtask

    // Drives one frame; the start is presented in the current cycle.
    task automatic run_frame(input int fea, input int p, input int npix,
                             input bit gaps, input bit send_stop);
        int          lim;
        int          x;
        int          y;
        bit          first;
        bit          last;
        bit          fin;
        bit          fin_seen;
        bit          sb;
        logic [34:0] bk;
        lim       = (fea / p) * p;
        fin_seen  = 1'b0;
        in_ctrl   = '{start: 1'b1, valid: 1'b0, stop: 1'b0};
        fea_size  = LW'(fea);
        pool_size = LW'(p);
        exp_q.push_back({32'(cyc + D), 3'b100});
        tick();
        in_ctrl = '0;
        @(negedge clk);
        check_eq("busy_after_start", busy, 64'd1);
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                tick();
                in_ctrl = '0;
            end
            tick();
            if (fea == 0) begin
                first = 1'b1;
                last  = 1'b0;
                fin   = 1'b0;
            end else begin
                x     = i % fea;
                y     = i / fea;
                first = (x % p == 0) && (y % p == 0);
                last  = (x % p == p - 1) && (y % p == p - 1) && (x < lim) && (y < lim);
                fin   = (lim > 0) && (x == lim - 1) && (y == lim - 1);
            end
            sb      = send_stop && (i == npix - 1);
            in_ctrl = '{start: 1'b0, valid: 1'b1, stop: sb};
            pool_q.push_back({32'(cyc + 1), 1'b1, first, last});
            if (last) begin
                exp_q.push_back({32'(cyc + D), 1'b0, 1'b1, fin || (sb && !fin_seen)});
            end else if (sb && !fin_seen) begin
                bk = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : '0;
                if (bk[1] && int'(bk[34:3]) > cyc) exp_q[exp_q.size()-1] = bk | 35'd1;
                else exp_q.push_back({32'(cyc + D), 3'b001});
            end
            if (fin) fin_seen = 1'b1;
        end
        tick();
        in_ctrl = '0;
        if (send_stop) begin
            @(negedge clk);
            check_eq("busy_after_stop", busy, 64'd0);
        end
    endtask

    initial begin
        xrst      = 1'b1;
        in_ctrl   = '0;
        fea_size  = '0;
        pool_size = '0;
        do_reset(3);

        run_frame(4, 2, 16, 1'b0, 1'b1);
        run_frame(5, 2, 25, 1'b0, 1'b1);
        run_frame(4, 1, 16, 1'b0, 1'b1);
        run_frame(4, 2, 16, 1'b1, 1'b1);
        run_frame(3, 3, 9, 1'b0, 1'b1);
        run_frame(4, 2, 7, 1'b0, 1'b1);
        run_frame(4, 2, 10, 1'b0, 1'b1);
        run_frame(0, 2, 1, 1'b0, 1'b1);

        run_frame(4, 2, 10, 1'b0, 1'b0);
        do_reset(1);
        run_frame(2, 2, 4, 1'b0, 1'b1);
`ifdef CTRL_POOL_ERR_EN
        check_eq("proto_err_clean", proto_err, 64'd0);
`endif

        run_frame(4, 2, 3, 1'b0, 1'b0);
        run_frame(2, 2, 4, 1'b0, 1'b1);
`ifdef CTRL_POOL_ERR_EN
        check_eq("proto_err_restart", proto_err, 64'd1);
        run_frame(2, 2, 4, 1'b0, 1'b1);
        check_eq("proto_err_sticky", proto_err, 64'd1);
`endif

        repeat (D + 4) tick();
        check_eq("end_exp_q_empty", exp_q.size(), 64'd0);
        check_eq("end_pool_q_empty", pool_q.size(), 64'd0);
        check_eq("end_busy", busy, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
